// File: rtl/bcd_subtractor_serial.sv
// Digit-serial BCD subtractor: D = X - Y - bin, one BCD digit per clock,
// least-significant digit first, with a start/busy/done handshake, a borrow-out
// sign flag, an invalid-digit error flag and per-digit seven-segment codes.
//
// Optional build macro BCD_SUB_SIGN_MAGNITUDE_EN: when defined, a negative
// result is converted from ten's complement to its magnitude in a FIX pass of
// DIGITS extra cycles. When undefined, negative results stay in ten's
// complement and the FIX state does not exist.
module bcd_subtractor_serial #(
  parameter int DIGITS = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [4*DIGITS-1:0]   X,
  input  logic [4*DIGITS-1:0]   Y,
  input  logic                  bin,
  output logic [4*DIGITS-1:0]   D,
  output logic                  negative,
  output logic                  error,
  output logic                  busy,
  output logic                  done,
  output logic [7*DIGITS-1:0]   SEG
);

  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(DIGITS - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_SUB  = 2'd1;
`ifdef BCD_SUB_SIGN_MAGNITUDE_EN
  localparam logic [1:0] S_FIX  = 2'd2;
`endif
  localparam logic [1:0] S_FIN  = 2'd3;

  logic [1:0]          state;
  logic [IW-1:0]       idx;
  logic                borrow;
  logic [4*DIGITS-1:0] x_reg;
  logic [4*DIGITS-1:0] y_reg;

  logic [3:0] digit_a;
  logic [3:0] digit_b;
  logic [4:0] diff5;
  logic [3:0] dig_out;
  logic       dig_borrow;
  logic       invalid_in;

  // Seven-segment code, active-high, bit order {g,f,e,d,c,b,a}; A-F shown as hex.
  function automatic logic [6:0] seg_of(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'h0: s = 7'h3F;
      4'h1: s = 7'h06;
      4'h2: s = 7'h5B;
      4'h3: s = 7'h4F;
      4'h4: s = 7'h66;
      4'h5: s = 7'h6D;
      4'h6: s = 7'h7D;
      4'h7: s = 7'h07;
      4'h8: s = 7'h7F;
      4'h9: s = 7'h6F;
      4'hA: s = 7'h77;
      4'hB: s = 7'h7C;
      4'hC: s = 7'h39;
      4'hD: s = 7'h5E;
      4'hE: s = 7'h79;
      default: s = 7'h71;
    endcase
    return s;
  endfunction

  // Flag any incoming X or Y digit above 9 so it can be captured with the operands.
  always_comb begin
    // NOTE: every variable assigned in always_comb gets a default first, so no latch is inferred.
    invalid_in = 1'b0;
    for (int k = 0; k < DIGITS; k++) begin
      if (X[4*k +: 4] > 4'd9 || Y[4*k +: 4] > 4'd9) invalid_in = 1'b1;
    end
  end

  // Single-digit subtract with borrow; FIX reuses it as 0 - Dk - borrow.
  always_comb begin
    digit_a = x_reg[idx*4 +: 4];
    digit_b = y_reg[idx*4 +: 4];
`ifdef BCD_SUB_SIGN_MAGNITUDE_EN
    if (state == S_FIX) begin
      digit_a = 4'd0;
      digit_b = D[idx*4 +: 4];
    end
`endif
    diff5 = {1'b0, digit_a} - {1'b0, digit_b} - {4'd0, borrow};
    if (diff5[4]) begin
      dig_out    = diff5[3:0] + 4'd10;
      dig_borrow = 1'b1;
    end else begin
      dig_out    = diff5[3:0];
      dig_borrow = 1'b0;
    end
  end

  // Control FSM plus operand, result and flag registers.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: the operand registers are reset too; they are plain flops, not a memory, so this is cheap and keeps simulation X-free.
    if (!rst_n) begin
      state    <= S_IDLE;
      idx      <= '0;
      borrow   <= 1'b0;
      x_reg    <= '0;
      y_reg    <= '0;
      D        <= '0;
      negative <= 1'b0;
      error    <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            x_reg  <= X;
            y_reg  <= Y;
            D      <= '0;
            error  <= invalid_in;
            busy   <= 1'b1;
            idx    <= '0;
            borrow <= bin;
            state  <= S_SUB;
          end
        end
        S_SUB: begin
          D[idx*4 +: 4] <= dig_out;
          borrow        <= dig_borrow;
          if (idx == LAST_IDX) begin
            negative <= dig_borrow;
            idx      <= '0;
`ifdef BCD_SUB_SIGN_MAGNITUDE_EN
            if (dig_borrow) begin
              borrow <= 1'b0;
              state  <= S_FIX;
            end else begin
              busy  <= 1'b0;
              state <= S_FIN;
            end
`else
            busy  <= 1'b0;
            state <= S_FIN;
`endif
          end else begin
            idx <= idx + 1'b1;
          end
        end
`ifdef BCD_SUB_SIGN_MAGNITUDE_EN
        S_FIX: begin
          D[idx*4 +: 4] <= dig_out;
          borrow        <= dig_borrow;
          if (idx == LAST_IDX) begin
            idx   <= '0;
            busy  <= 1'b0;
            state <= S_FIN;
          end else begin
            idx <= idx + 1'b1;
          end
        end
`endif
        S_FIN: begin
          done  <= 1'b1;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Decode each registered result digit for the display.
  always_comb begin
    SEG = '0;
    for (int k = 0; k < DIGITS; k++) begin
      SEG[7*k +: 7] = seg_of(D[4*k +: 4]);
    end
  end

endmodule

// File: tb/tb_bcd_subtractor_serial.sv
// Self-checking bench for bcd_subtractor_serial (DIGITS=2): a directed vector
// table, hand-written handshake/reset sequences, and random operands compared
// against an integer-arithmetic reference model. Honours BCD_SUB_SIGN_MAGNITUDE_EN.
module tb_bcd_subtractor_serial;

  localparam int N   = 2;
  localparam int MOD = 100;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [7:0]   X;
  logic [7:0]   Y;
  logic         bin;
  logic [7:0]   D;
  logic         negative;
  logic         error;
  logic         busy;
  logic         done;
  logic [13:0]  SEG;

  int checks;
  int errors;

  bcd_subtractor_serial #(.DIGITS(N)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .X(X), .Y(Y), .bin(bin),
    .D(D), .negative(negative), .error(error), .busy(busy), .done(done), .SEG(SEG)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] x;
    logic [7:0] y;
    logic       b;
    logic [7:0] d;
    logic       neg;
    logic       err;
    logic       chk_d;
  } vec_t;

  logic [6:0] seg_ref [10];

  // Observations captured by run_op.
  logic       first_busy;
  logic       first_err;
  logic [7:0] first_d;
  int         overlap_cnt;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int bcd_val(input logic [7:0] v);
    return int'(v[7:4]) * 10 + int'(v[3:0]);
  endfunction

  function automatic logic [7:0] to_bcd(input int v);
    logic [3:0] hi;
    logic [3:0] lo;
    hi = 4'(v / 10);
    lo = 4'(v % 10);
    return {hi, lo};
  endfunction

  // Reference: plain integer subtraction on decimal values.
  task automatic model(input logic [7:0] x, input logic [7:0] y, input logic b,
                       output logic [7:0] d, output logic neg, output int lat);
    int diff;
    diff = bcd_val(x) - bcd_val(y) - int'(b);
    neg  = (diff < 0);
    lat  = N + 2;
`ifdef BCD_SUB_SIGN_MAGNITUDE_EN
    d = to_bcd((neg ? -diff : diff) % MOD);
    if (neg) lat = lat + N;
`else
    d = to_bcd((diff + MOD) % MOD);
`endif
  endtask

  function automatic int exp_lat(input logic neg);
`ifdef BCD_SUB_SIGN_MAGNITUDE_EN
    return neg ? 2 * N + 2 : N + 2;
`else
    return (neg === 1'bx) ? 0 : N + 2;
`endif
  endfunction

  // Launch one operation from IDLE (or the done cycle) and wait for done.
  // lat counts falling edges after the accepting edge up to the done cycle.
  task automatic run_op(input logic [7:0] x, input logic [7:0] y, input logic b,
                        output int lat, output logic ok);
    X = x; Y = y; bin = b; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    lat = 0;
    ok  = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      lat++;
      if (lat == 1) begin
        first_busy = busy;
        first_err  = error;
        first_d    = D;
      end
      if (busy && done) overlap_cnt++;
      if (done) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic check_result(input string tag, input logic [7:0] d, input logic neg);
    check({tag, "_d"}, D, d);
    check({tag, "_neg"}, negative, neg);
    check({tag, "_seg0"}, SEG[6:0], seg_ref[d[3:0]]);
    check({tag, "_seg1"}, SEG[13:7], seg_ref[d[7:4]]);
  endtask

  vec_t tbl [7];

  initial begin
    int         lat;
    logic       ok;
    logic [7:0] ed;
    logic       en;
    int         el;
    int         done_cnt;
    int         busy_cnt;

    checks = 0; errors = 0; overlap_cnt = 0;
    seg_ref[0] = 7'h3F; seg_ref[1] = 7'h06; seg_ref[2] = 7'h5B; seg_ref[3] = 7'h4F;
    seg_ref[4] = 7'h66; seg_ref[5] = 7'h6D; seg_ref[6] = 7'h7D; seg_ref[7] = 7'h07;
    seg_ref[8] = 7'h7F; seg_ref[9] = 7'h6F;

    //            x      y     b     d      neg   err   chk_d
    tbl[0] = '{8'h45, 8'h17, 1'b0, 8'h28, 1'b0, 1'b0, 1'b1};
`ifdef BCD_SUB_SIGN_MAGNITUDE_EN
    tbl[1] = '{8'h17, 8'h45, 1'b0, 8'h28, 1'b1, 1'b0, 1'b1};
    tbl[2] = '{8'h00, 8'h00, 1'b1, 8'h01, 1'b1, 1'b0, 1'b1};
    tbl[6] = '{8'h05, 8'h50, 1'b1, 8'h46, 1'b1, 1'b0, 1'b1};
`else
    tbl[1] = '{8'h17, 8'h45, 1'b0, 8'h72, 1'b1, 1'b0, 1'b1};
    tbl[2] = '{8'h00, 8'h00, 1'b1, 8'h99, 1'b1, 1'b0, 1'b1};
    tbl[6] = '{8'h05, 8'h50, 1'b1, 8'h54, 1'b1, 1'b0, 1'b1};
`endif
    tbl[3] = '{8'h99, 8'h99, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1};
    tbl[4] = '{8'h3A, 8'h10, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0};
    tbl[5] = '{8'h10, 8'h09, 1'b1, 8'h00, 1'b0, 1'b0, 1'b1};

    // Reset state.
    rst_n = 1'b0; start = 1'b0; X = '0; Y = '0; bin = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_d", D, 8'h00);
    check("rst_flags", {negative, error, busy, done}, 4'b0000);
    check("rst_seg", SEG, {seg_ref[0], seg_ref[0]});
    rst_n = 1'b1;
    @(negedge clk);

    // Directed table.
    for (int i = 0; i < 7; i++) begin
      run_op(tbl[i].x, tbl[i].y, tbl[i].b, lat, ok);
      check($sformatf("tbl%0d_done", i), ok, 1'b1);
      check($sformatf("tbl%0d_busy_t0", i), first_busy, 1'b1);
      check($sformatf("tbl%0d_d_clear", i), first_d, 8'h00);
      check($sformatf("tbl%0d_err_t0", i), first_err, tbl[i].err);
      check($sformatf("tbl%0d_lat", i), lat, exp_lat(tbl[i].neg));
      check($sformatf("tbl%0d_err", i), error, tbl[i].err);
      if (tbl[i].chk_d) check_result($sformatf("tbl%0d", i), tbl[i].d, tbl[i].neg);
    end

    // Error flag holds after done until the next accepted start.
    run_op(8'h3A, 8'h10, 1'b0, lat, ok);
    repeat (3) @(negedge clk);
    check("err_hold", error, 1'b1);
    run_op(8'h45, 8'h17, 1'b0, lat, ok);
    check("err_cleared", error, 1'b0);

    // start held through SUB and FIN: one operation, one done.
    X = 8'h45; Y = 8'h17; bin = 1'b0; start = 1'b1;
    repeat (N + 2) @(posedge clk);
    #1 start = 1'b0;
    X = 8'h99; Y = 8'h00;
    done_cnt = 0; busy_cnt = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (done) done_cnt++;
      if (busy) busy_cnt++;
    end
    check("held_done_cnt", done_cnt, 1);
    check("held_no_restart", busy_cnt, 0);
    check_result("held", 8'h28, 1'b0);

    // Second start during SUB is ignored; the captured operands are used.
    X = 8'h83; Y = 8'h27; bin = 1'b0; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    @(posedge clk);
    #1 X = 8'h11; Y = 8'h11; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    done_cnt = 0; busy_cnt = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (done) done_cnt++;
      if (done_cnt == 1 && busy) busy_cnt++;
    end
    check("sub_ignore_done_cnt", done_cnt, 1);
    check("sub_ignore_no_restart", busy_cnt, 0);
    check_result("sub_ignore", 8'h56, 1'b0);

    // Start in the cycle right after FIN (the done cycle) is accepted.
    run_op(8'h62, 8'h13, 1'b0, lat, ok);
    run_op(8'h70, 8'h25, 1'b1, lat, ok);
    check("b2b_done", ok, 1'b1);
    check("b2b_lat", lat, N + 2);
    check_result("b2b", 8'h44, 1'b0);

    // Reset during SUB index 1.
    X = 8'h45; Y = 8'h17; bin = 1'b0; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_d", D, 8'h00);
    check("mid_rst_flags", {negative, error, busy, done}, 4'b0000);
    done_cnt = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (done) done_cnt++;
    end
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (done || busy) done_cnt++;
    end
    check("mid_rst_no_done", done_cnt, 0);
    run_op(8'h31, 8'h47, 1'b0, lat, ok);
    model(8'h31, 8'h47, 1'b0, ed, en, el);
    check("post_rst_done", ok, 1'b1);
    check("post_rst_lat", lat, el);
    check_result("post_rst", ed, en);

    // Random valid operands against the reference model.
    for (int i = 0; i < 40; i++) begin
      logic [7:0] rx;
      logic [7:0] ry;
      logic       rb;
      rx = {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
      ry = {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
      rb = 1'($urandom_range(0, 1));
      model(rx, ry, rb, ed, en, el);
      run_op(rx, ry, rb, lat, ok);
      check($sformatf("rnd%0d_done", i), ok, 1'b1);
      check($sformatf("rnd%0d_lat", i), lat, el);
      check($sformatf("rnd%0d_err", i), error, 1'b0);
      check_result($sformatf("rnd%0d", i), ed, en);
    end

    // Random operands with possibly invalid digits: only the error flag is defined.
    for (int i = 0; i < 20; i++) begin
      logic [7:0] rx;
      logic [7:0] ry;
      logic       inv;
      rx = 8'($urandom_range(0, 255));
      ry = 8'($urandom_range(0, 255));
      inv = (rx[7:4] > 9) || (rx[3:0] > 9) || (ry[7:4] > 9) || (ry[3:0] > 9);
      run_op(rx, ry, 1'b0, lat, ok);
      check($sformatf("rinv%0d_done", i), ok, 1'b1);
      check($sformatf("rinv%0d_err", i), error, inv);
    end

    check("done_busy_overlap", overlap_cnt, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/bcd_subtractor_serial.md
Name: bcd_subtractor_serial

Overview:
- Digit-serial multi-digit BCD subtractor. Computes X − Y − bin, one BCD digit per clock, least-significant digit first.
- Companion to the combinational BCD adder used on the display boards.
- Provides a start/busy/done handshake, a borrow-out sign flag, an invalid-digit error flag, and seven-segment codes per result digit.
- Used by the calculator datapath for the subtract operation.

Parameters:
- DIGITS, 2, number of BCD digits per operand (1..8).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request; sampled only when busy=0.
- X  input  4*DIGITS  minuend, BCD; digit k is X[4k+3:4k].
- Y  input  4*DIGITS  subtrahend, BCD.
- bin  input  1  borrow in.
- D  output  4*DIGITS  difference, BCD, registered.
- negative  output  1  final borrow out (X < Y+bin).
- error  output  1  any captured X or Y digit > 9.
- busy  output  1  operation in progress.
- done  output  1  one-cycle completion pulse.
- SEG  output  7*DIGITS  seven-segment code of each D digit. Uses the team's hex-10 decoder encoding, decoded combinationally from registered D.

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous, active-low, on rst_n.
- Reset values: D=0, negative=0, error=0, busy=0, done=0, state=IDLE, digit index=0, borrow register=0.
- States: IDLE, SUB, FIX (only with the optional feature), FIN.
- IDLE:
  - On an edge with start=1, capture X, Y and bin into operand registers.
  - Clear D.
  - error <= OR of (digit > 9) over all X and Y digits.
  - busy <= 1, index <= 0, borrow <= bin, go to SUB.
- SUB, one digit per edge at index k:
  - t = Xk − Yk − borrow, computed 5-bit signed.
  - If t < 0: Dk <= t+10 and borrow <= 1. Otherwise Dk <= t and borrow <= 0.
  - Invalid digits are processed with the same arithmetic, truncated to 4 bits. The result is don't-care when error=1.
  - After index DIGITS−1, go to FIN (or FIX, see Optional Feature). negative <= final borrow.
- FIN lasts one cycle: done=1, busy=0, then return to IDLE. D, negative and error hold until the next accepted start.
- Latency: start accepted at edge t0. D is final after edge t0+DIGITS. done is high during the cycle following edge t0+DIGITS+1. busy is high from t0 through the SUB and FIX cycles.
- start while busy=1 is ignored; it is not queued.
- start during the FIN cycle is ignored, because busy is low but the state is not IDLE. start is accepted from the following cycle.
- done never coincides with busy=1.
- Without the optional feature, a negative result is left in ten's complement. Example: 17−45 gives D=72 with negative=1.
- Reset asserted mid-operation returns immediately to the reset values. The partial result is discarded and no done is issued.

Optional Feature:
- Macro: BCD_SUB_SIGN_MAGNITUDE_EN.
- Defined: after SUB, if the final borrow is 1, enter FIX for DIGITS cycles.
  - FIX computes 0 − Dk − borrow using the same digit datapath, with borrow initialised to 0. This converts D to its magnitude, 10^DIGITS − D.
  - negative stays 1. FIN follows FIX.
  - Latency for negative results grows by DIGITS cycles. Positive results are unchanged.
- Undefined: the FIX state and its logic are absent. D is in ten's complement when negative=1.

Test Plan (DIGITS=2):
- X=0x45, Y=0x17, bin=0, start pulse → D=0x28, negative=0, error=0; done one cycle after edge t0+3; SEG shows 2,8.
- X=0x17, Y=0x45, bin=0 → feature off: D=0x72, negative=1. Feature on: D=0x28, negative=1, done 2 cycles later.
- X=0x00, Y=0x00, bin=1 → negative=1; D=0x99 (feature off) or 0x01 (feature on). X=0x99, Y=0x99, bin=0 → D=0x00, negative=0.
- X=0x3A, Y=0x10 → error=1 from the capture edge until the next accepted start; done still pulses once.
- start held high for 5 cycles → exactly one operation and one done pulse. A second start pulse during the SUB cycles is ignored; a start pulse in the cycle after FIN is accepted with new operands.
- rst_n low during SUB index 1 → all outputs 0 at once; no done pulse; a fresh start after release gives the correct result.
